// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the WISC fetch stage: opcode values, fetch FSM
// encoding and a small decode helper.
package instr_fetch_pkg;

  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HALT  = 1'b1
  } if_state_e;

  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:12] == OP_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_slot.sv
// One-entry IF/ID output register: holds an instruction and its PC+1 for decode.
// Priority: reset, flush, load, consume; otherwise contents are held.
module if_id_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        consume_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_plus1_i,
  output logic        valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] pc_plus1_o
);

  logic        valid_q;
  logic [15:0] instr_q;
  logic [15:0] pc_plus1_q;

  // Slot register update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= 16'h0000;
      pc_plus1_q <= 16'h0000;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus1_q <= pc_plus1_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/instr_fetch.sv
// WISC instruction fetch stage: owns the PC, issues word reads to instruction
// memory, feeds decode through a one-entry slot, and stops after HLT drains.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus1,
  output logic        halted
);

  logic [15:0] pc_q;
  if_state_e   state_q;
  logic        halted_q;

  logic        slot_free_s;
  logic        accept_s;
  logic        redirect_s;
  logic        consume_s;
  logic        hlt_leave_s;
  logic [15:0] pc_plus1_s;

  assign slot_free_s = !if_valid || !id_stall;
  assign imem_req    = (state_q == IF_FETCH) && slot_free_s && !redirect && !rst;
  assign imem_addr   = pc_q;
  assign accept_s    = imem_req && imem_rdy;
  // Once halted, downstream redirects can no longer restart the core.
  assign redirect_s  = redirect && !halted_q;
  assign consume_s   = if_valid && !id_stall && !redirect_s;
  assign hlt_leave_s = consume_s && is_hlt(if_instr);
  assign pc_plus1_s  = pc_q + 16'd1;

  // PC, fetch FSM and sticky halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= IF_FETCH;
      halted_q <= 1'b0;
    end else if (redirect_s) begin
      pc_q    <= redirect_pc;
      state_q <= IF_FETCH;
    end else begin
      if (accept_s) begin
        pc_q <= pc_plus1_s;
        if (is_hlt(imem_rdata)) begin
          state_q <= IF_HALT;
        end
      end
      if (hlt_leave_s) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign halted = halted_q;

  if_id_slot u_slot (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept_s),
    .flush_i    (redirect_s),
    .consume_i  (consume_s),
    .instr_i    (imem_rdata),
    .pc_plus1_i (pc_plus1_s),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_plus1_o (if_pc_plus1)
  );

endmodule
